conv_result_sink: RTL and testbench
===================================

Name: conv_result_sink

Overview:
Downstream end of the fifo→convolution pipeline. Captures each 16-bit convolution result strobed by `conv_done`, scales it and saturates it to an 8-bit pixel. Buffers pixels in a small FIFO and presents them on a valid/ready stream to the frame writer. Tracks results per frame, stops accepting at the frame boundary, and pulses `frame_done` once the last pixel of the frame has drained.

Parameters:
- DATA_W, 16: width of the incoming convolution result `data_i` (unsigned).
- SHIFT, 4: right-shift applied to each result before saturation.
- DEPTH, 8: FIFO entries; must be a power of 2, ≥2.
- FRAME_LEN, 9: results per frame (3x3 kernel over a 5x5 image); ≥1.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- conv_done  in  1  one-cycle strobe: `data_i` holds a valid result this cycle.
- data_i  in  DATA_W  convolution result.
- pix_o  out  8  head-of-FIFO pixel.
- pix_valid  out  1  `pix_o` valid (FIFO not empty).
- pix_ready  in  1  downstream accepts `pix_o` this cycle.
- frame_done  out  1  one-cycle pulse, last pixel of the frame popped.
- overflow  out  1  sticky; a result was dropped.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate): `pix_o`=0, `pix_valid`=0, `frame_done`=0, `overflow`=0, `level`=0. FIFO pointers and rx/tx counters are 0, state=IDLE. Reset mid-frame discards all buffered data.
- Arithmetic: `s = data_i >> SHIFT` (logical); `pix = (s > 255) ? 8'hFF : s[7:0]`. The result is computed combinationally and written at the push edge.
- Push:
  - Occurs at a posedge where `conv_done`=1, state ∈ {IDLE, RUN}, and the FIFO is not full, or is full with a pop on the same edge.
  - Otherwise `conv_done`=1 drops the result and sets `overflow`, which stays set until reset.
- Pop: occurs at a posedge where `pix_valid`=1 and `pix_ready`=1.
- Latency:
  - A push at edge k makes `pix_valid`=1 after edge k when the FIFO was empty.
  - `pix_o` is driven combinationally from the head entry, so zero extra latency.
- Simultaneous push and pop: `level` is unchanged; legal at full and at empty+push (the pop requires `pix_valid`, so at empty only the push occurs).
- Pointers wrap modulo DEPTH. `level` = wr−rd and ranges 0..DEPTH.
- State machine:
  - IDLE: no result yet this frame. First push → RUN, rx_cnt=1. If FRAME_LEN=1 the first push goes → DRAIN instead.
  - RUN: each push increments rx_cnt. The push that makes rx_cnt=FRAME_LEN → DRAIN.
  - DRAIN: pushes are blocked; any `conv_done` here is dropped and sets `overflow`. Pops continue.
  - The pop that makes tx_cnt=FRAME_LEN → DONE.
  - DONE: `frame_done`=1 for exactly this one cycle. rx_cnt and tx_cnt clear to 0. Next edge → IDLE. `conv_done` in DONE is dropped and sets `overflow`.
- tx_cnt increments on every pop in any state. Pops in IDLE/RUN belong to the current frame. Because pushes stop at FRAME_LEN, tx_cnt never exceeds FRAME_LEN.
- `pix_ready` with `pix_valid`=0: no effect.
- `frame_done` is registered (asserted in the cycle after the final pop edge).

Test Plan:
1. Single result, SHIFT=4: `data_i`=16'h0123 with `conv_done` pulse, `pix_ready`=1 → `pix_valid` high one cycle with `pix_o`=8'h12, `level` 1→0.
2. Saturation: `data_i`=16'h1000 → `pix_o`=8'hFF; `data_i`=16'h0FF0 → 8'hFF; `data_i`=16'h000F → 8'h00.
3. Full frame, FRAME_LEN=9, `pix_ready`=1:
   - Stimulus: 9 strobes of 16'h0010·n, n=1..9.
   - Response: `pix_o` sequence 01..09, in order.
   - `frame_done` pulses once, one cycle after the 9th pop; state returns to IDLE; `overflow`=0.
4. Backpressure and overflow, `pix_ready`=0, DEPTH=8:
   - 9 strobes → `level` saturates at 8 and the 9th result is dropped; `overflow`=1 and stays 1.
   - Releasing `pix_ready` drains 8 pixels in order; no `frame_done` (rx_cnt=8<9).
5. Push+pop at full:
   - With `level`=8, assert `conv_done` and `pix_ready` on the same edge → `level` stays 8, head advances, no overflow.
   - The new entry emerges 8 pops later.
6. Boundary and reset:
   - `conv_done` during DRAIN → `overflow`=1; that value never appears on `pix_o`.
   - Assert `rst` mid-DRAIN with `level`=3 → `pix_valid`, `level`, `overflow` are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/conv_result_sink.sv
// Scales and saturates convolution results to 8-bit pixels and streams them out through a small FIFO.
// Tracks a frame of FRAME_LEN results, blocks pushes at the boundary, and pulses frame_done after the final pop.
module conv_result_sink #(
  parameter int DATA_W    = 16,
  parameter int SHIFT     = 4,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     conv_done,
  input  logic [DATA_W-1:0]        data_i,
  output logic [7:0]               pix_o,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]     rx_cnt, tx_cnt, rx_nxt, tx_nxt;
  logic [DATA_W-1:0] scaled;
  logic [7:0]        pix_in;
  logic              full, accepting, push, pop;

  assign scaled    = data_i >> SHIFT;
  assign pix_in    = (|scaled[DATA_W-1:8]) ? 8'hFF : scaled[7:0];

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level     = wr_ptr - rd_ptr;
  assign pix_valid = (level != '0);
  assign full      = (level == (AW+1)'(DEPTH));
  assign pop       = pix_valid & pix_ready;
  assign accepting = (state == IDLE) || (state == RUN);
  assign push      = conv_done & accepting & (~full | pop);

  assign pix_o      = pix_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pix_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (conv_done && !push) overflow <= 1'b1;
      rx_cnt <= rx_nxt;
      tx_cnt <= tx_nxt;
      state  <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rx_nxt    = rx_cnt;
    tx_nxt    = tx_cnt;
    if (push) rx_nxt = rx_cnt + 1'b1;
    if (pop)  tx_nxt = tx_cnt + 1'b1;
    case (state)
      IDLE, RUN: begin
        if (push) begin
          if (rx_cnt == CW'(FRAME_LEN - 1)) state_nxt = DRAIN;
          else                              state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (pop && tx_cnt == CW'(FRAME_LEN - 1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        rx_nxt    = '0;
        tx_nxt    = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_result_sink.sv
// Scoreboard bench for conv_result_sink: expected pixels queued at strobe time, compared as they pop.
module tb_conv_result_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        conv_done = 1'b0;
  logic [15:0] data_i = '0;
  logic        pix_ready = 1'b0;
  logic [7:0]  pix_o;
  logic        pix_valid;
  logic        frame_done;
  logic        overflow;
  logic [3:0]  level;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  logic [7:0] exp_q[$];

  conv_result_sink dut (
    .clk        (clk),
    .rst        (rst),
    .conv_done  (conv_done),
    .data_i     (data_i),
    .pix_o      (pix_o),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_done (frame_done),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] model_pix(input logic [15:0] d);
    logic [15:0] s;
    s = d >> 4;
    return (s > 16'd255) ? 8'hFF : s[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] d, input bit acc);
    conv_done = 1'b1;
    data_i    = d;
    if (acc) exp_q.push_back(model_pix(d));
    tick();
    conv_done = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    conv_done = 1'b0;
    pix_ready = 1'b0;
    tick();
    exp_q.delete();
    fd_cnt = 0;
    rst = 1'b0;
    tick();
  endtask

  // A pop will happen at the next posedge; compare the head against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", pix_valid, 0);
        else                   chk("pix", pix_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_pix", pix_o, 0);
    do_reset();

    // single result
    pix_ready = 1'b1;
    strobe(16'h0123, 1'b1);
    chk("t1_level1", level, 1);
    chk("t1_valid", pix_valid, 1);
    chk("t1_pix", pix_o, 8'h12);
    tick();
    chk("t1_level0", level, 0);
    chk("t1_valid0", pix_valid, 0);

    // saturation
    strobe(16'h1000, 1'b1);
    strobe(16'h0FF0, 1'b1);
    strobe(16'h000F, 1'b1);
    repeat (3) tick();
    chk("t2_drained", exp_q.size(), 0);

    // full frame
    do_reset();
    pix_ready = 1'b1;
    for (int n = 1; n <= 9; n++) strobe(16'(16'h0010 * n), 1'b1);
    tick();
    chk("t3_fd_hi", frame_done, 1);
    tick();
    chk("t3_fd_lo", frame_done, 0);
    repeat (3) tick();
    chk("t3_fd_cnt", fd_cnt, 1);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_ovf", overflow, 0);
    strobe(16'h0500, 1'b1);
    chk("t3_next_frame", pix_valid, 1);
    tick();
    chk("t3_ovf2", overflow, 0);

    // backpressure and overflow
    do_reset();
    for (int n = 1; n <= 8; n++) strobe(16'(16'h0100 * n), 1'b1);
    strobe(16'h0FFF, 1'b0);
    chk("t4_level", level, 8);
    chk("t4_ovf", overflow, 1);
    pix_ready = 1'b1;
    repeat (10) tick();
    chk("t4_level0", level, 0);
    chk("t4_ovf_sticky", overflow, 1);
    chk("t4_no_fd", fd_cnt, 0);
    chk("t4_drained", exp_q.size(), 0);

    // push+pop at full
    do_reset();
    for (int n = 1; n <= 8; n++) strobe(16'(16'h0100 * n), 1'b1);
    chk("t5_full", level, 8);
    pix_ready = 1'b1;
    strobe(16'h0990, 1'b1);
    pix_ready = 1'b0;
    chk("t5_level", level, 8);
    chk("t5_ovf", overflow, 0);
    chk("t5_head", pix_o, 8'h20);
    pix_ready = 1'b1;
    repeat (10) tick();
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_fd_cnt", fd_cnt, 1);

    // conv_done during DRAIN, then reset mid-drain
    do_reset();
    for (int n = 1; n <= 8; n++) strobe(16'(16'h0110 * n), 1'b1);
    pix_ready = 1'b1;
    strobe(16'h0990, 1'b1);
    pix_ready = 1'b0;
    chk("t6_ovf_pre", overflow, 0);
    strobe(16'h0AA0, 1'b0);
    chk("t6_ovf", overflow, 1);
    chk("t6_level8", level, 8);
    pix_ready = 1'b1;
    repeat (5) tick();
    pix_ready = 1'b0;
    chk("t6_level3", level, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", pix_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_ovf", overflow, 0);
    tick();
    exp_q.delete();
    rst = 1'b0;
    tick();
    chk("t6_post_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
